// File: rtl/geig_stack_serializer.sv
// geig_stack_serializer
//   Detects each new 48-bit Geiger data stack, buffers one stack and sends it
//   to the flight computer as a UART byte stream (1 start, 8 data LSB first,
//   1 stop), id byte first, counts high byte last.
//
//   Optional feature macro: GEIG_SER_CHECKSUM_EN
//     defined   -> a 7th byte (XOR of bytes 0..5) is appended to every frame
//     undefined -> 6-byte frames, no checksum logic
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (2..1023), default 10
// Ports
//   CLK_100KHZ    in   system clock, rising edge
//   RESET         in   asynchronous active-low reset
//   G_DATA_STACK  in   {counts[47:32], timestamp[31:8], id[7:0]}, slow domain
//   TX            out  UART serial line, idle high
//   BUSY          out  high while a frame is being shifted out
//   DROP          out  sticky: a buffered, unsent stack was overwritten
module geig_stack_serializer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic        CLK_100KHZ,
  input  logic        RESET,
  input  logic [47:0] G_DATA_STACK,
  output logic        TX,
  output logic        BUSY,
  output logic        DROP
);

`ifdef GEIG_SER_CHECKSUM_EN
  localparam int NBYTES = 7;
`else
  localparam int NBYTES = 6;
`endif
  localparam int FW    = 8 * NBYTES;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST    = 3'(NBYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_NEXT} state_e;

  // capture / buffer
  logic [47:0] s1_q, s2_q, last_q, pend_q;
  logic        pend_v_q, pend_v_d;
  logic        drop_q, drop_d;
  logic        accept;
  logic        consume;

  // serializer
  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      byte_q, byte_d;
  logic [FW-1:0]   shreg_q, shreg_d;
  logic [FW-1:0]   frame_load;

`ifdef GEIG_SER_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = '0;
    for (int k = 0; k < 6; k++) csum = csum ^ pend_q[8*k +: 8];
  end
  assign frame_load = {csum, pend_q};
`else
  assign frame_load = pend_q;
`endif

  // Two equal consecutive samples filter out values smeared across the
  // domain crossing; all-zero is the upstream reset value and never sent.
  assign accept = (s1_q == s2_q) && (s2_q != last_q) && (s2_q != 48'h0);

  // The FSM consumes the buffer before a simultaneous new stack lands, so
  // that case is not an overwrite.
  always_comb begin
    pend_v_d = pend_v_q;
    drop_d   = drop_q;
    if (consume) pend_v_d = 1'b0;
    if (accept) begin
      pend_v_d = 1'b1;
      if (pend_v_q && !consume) drop_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_100KHZ or negedge RESET) begin
    if (!RESET) begin
      s1_q     <= '0;
      s2_q     <= '0;
      last_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      s1_q     <= G_DATA_STACK;
      s2_q     <= s1_q;
      pend_v_q <= pend_v_d;
      drop_q   <= drop_d;
      if (accept) begin
        pend_q <= s2_q;
        last_q <= s2_q;
      end
    end
  end

  always_ff @(posedge CLK_100KHZ or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
    end
  end

  // The shift register moves one bit per data bit, so after 8 bits the next
  // byte already sits at the bottom.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    consume = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_v_q) begin
          consume = 1'b1;
          shreg_d = frame_load;
          byte_d  = '0;
          cnt_d   = CNT_MAX;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_MAX;
          bit_d   = '0;
          state_d = S_DATA;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_MAX;
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) state_d = S_STOP;
          else bit_d = bit_q + 1'b1;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_STOP: begin
        if (cnt_q == '0) state_d = S_NEXT;
        else cnt_d = cnt_q - 1'b1;
      end
      S_NEXT: begin
        // single TX-high cycle between bytes; no extra idle gap
        if (byte_q == LAST) state_d = S_IDLE;
        else begin
          byte_d  = byte_q + 1'b1;
          cnt_d   = CNT_MAX;
          state_d = S_START;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded from state so reset forces the line high asynchronously.
  assign TX   = (state_q == S_START) ? 1'b0 :
                (state_q == S_DATA)  ? shreg_q[0] : 1'b1;
  assign BUSY = (state_q != S_IDLE);
  assign DROP = drop_q;

endmodule

// File: tb/tb_geig_stack_serializer.sv
module tb_geig_stack_serializer;
  localparam int CPB = 10;
`ifdef GEIG_SER_CHECKSUM_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif
  localparam int FRAME = NB * (10 * CPB + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [47:0] g = '0;
  logic        tx, busy, drop;

  always #5 clk = ~clk;

  geig_stack_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .CLK_100KHZ(clk), .RESET(rst_n), .G_DATA_STACK(g),
    .TX(tx), .BUSY(busy), .DROP(drop)
  );

  int tests = 0, fails = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit busy_seen = 0, txlow_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // UART receiver: samples mid-bit on negedges.
  int m_ph = 0, m_cnt = 0;
  logic [7:0] m_byte = '0;
  always @(negedge clk) begin
    if (busy === 1'b1) busy_seen = 1;
    if (tx === 1'b0) txlow_seen = 1;
    if (rst_n !== 1'b1) m_ph = 0;
    else if (m_ph == 0) begin
      if (tx === 1'b0) begin m_ph = 1; m_cnt = CPB / 2; end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        if (m_ph == 1) begin
          if (tx === 1'b0) begin m_ph = 2; m_cnt = CPB; end
          else m_ph = 0;
        end else if (m_ph <= 9) begin
          m_byte[m_ph-2] = tx;
          m_ph++;
          m_cnt = CPB;
        end else begin
          chk("stop_bit", {63'd0, tx}, 64'd1);
          rx_q.push_back(m_byte);
          m_ph = 0;
        end
      end
    end
  end

  // Expected frame straight from the byte-order rule.
  task automatic push_stack(input logic [47:0] v);
    logic [7:0] ck;
    ck = '0;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(v[8*k +: 8]);
      ck = ck ^ v[8*k +: 8];
    end
    if (NB == 7) exp_q.push_back(ck);
  endtask

  task automatic check_rx(input string name);
    chk($sformatf("%s_len", name), 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), {56'd0, rx_q[i]}, {56'd0, exp_q[i]});
    rx_q.delete();
    exp_q.delete();
  endtask

  // lat: edges after edge n (first edge after the change) until TX is low.
  task automatic apply_measure(input logic [47:0] v, output int lat, output int blen);
    @(negedge clk);
    g = v;
    @(posedge clk);
    lat = 0;
    blen = 0;
    do begin @(posedge clk); #1; lat++; end while (tx !== 1'b0 && lat < 50);
    if (tx === 1'b0) begin
      blen = 1;
      while (blen < 3000) begin
        @(posedge clk); #1;
        if (busy !== 1'b1) break;
        blen++;
      end
    end
  endtask

  typedef struct {
    logic [47:0] stack;
    logic [47:0] order;  // bytes in transmit order, first byte in [47:40]
    logic [7:0]  ck;
  } vec_t;

  vec_t tbl[4];
  logic [47:0] cur, v, last_m;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, blen, w;
    tbl[0] = '{48'h0012_00A0B1_47, 48'h47B1A0001200, 8'h44};
    tbl[1] = '{48'h0102_030405_06, 48'h060504030201, 8'h07};
    tbl[2] = '{48'hFFFF_FFFFFF_FF, 48'hFFFFFFFFFFFF, 8'h00};
    tbl[3] = '{48'h8000_000000_01, 48'h010000000080, 8'h81};

    #2 rst_n = 1'b0;
    #1;
    chk("reset_tx", {63'd0, tx}, 64'd1);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_drop", {63'd0, drop}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // zero stack is never sent
    busy_seen = 0; txlow_seen = 0;
    repeat (2000) @(posedge clk);
    @(negedge clk);
    chk("idle_busy", {63'd0, busy_seen}, 64'd0);
    chk("idle_tx", {63'd0, txlow_seen}, 64'd0);
    chk("idle_drop", {63'd0, drop}, 64'd0);

    // table-driven frames
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 6; k++) exp_q.push_back(tbl[i].order[47-8*k -: 8]);
      if (NB == 7) exp_q.push_back(tbl[i].ck);
      apply_measure(tbl[i].stack, lat, blen);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
      chk($sformatf("vec%0d_busy_len", i), 64'(blen), 64'(FRAME));
      repeat (20) @(posedge clk);
      check_rx($sformatf("vec%0d", i));
    end

    // same stack held: no repeat; then timestamp-only change: one frame
    busy_seen = 0;
    repeat (5000) @(posedge clk);
    chk("hold_busy", {63'd0, busy_seen}, 64'd0);
    check_rx("hold");
    v = tbl[3].stack ^ 48'h0000_5A5A5A_00;
    push_stack(v);
    @(negedge clk) g = v;
    repeat (FRAME + 50) @(posedge clk);
    check_rx("ts_change");

    // one-cycle transient
    busy_seen = 0;
    @(negedge clk) g = 48'h1234_567890_AB;
    @(negedge clk) g = v;
    repeat (1000) @(posedge clk);
    chk("transient_busy", {63'd0, busy_seen}, 64'd0);
    chk("transient_drop", {63'd0, drop}, 64'd0);
    check_rx("transient");

    // buffer overwrite while a frame is in flight
    cur = v ^ 48'h0000_000100_00;
    push_stack(cur);
    @(negedge clk) g = cur;
    repeat (50) @(negedge clk);
    g = 48'hAAAA_000001_0A;
    repeat (100) @(negedge clk);
    chk("drop_after_A", {63'd0, drop}, 64'd0);
    g = 48'hBBBB_000002_0B;
    repeat (100) @(negedge clk);
    chk("drop_after_B", {63'd0, drop}, 64'd1);
    g = 48'hCCCC_000003_0C;
    push_stack(48'hCCCC_000003_0C);
    repeat (2 * FRAME + 100) @(posedge clk);
    check_rx("drop_frames");
    chk("drop_sticky", {63'd0, drop}, 64'd1);

    // reset during byte 2
    cur = 48'h0777_123456_3C;
    @(negedge clk) g = cur;
    w = 0;
    while (rx_q.size() < 2 && w < 3000) begin @(posedge clk); w++; end
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", {63'd0, tx}, 64'd1);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    g = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_drop", {63'd0, drop}, 64'd0);
    exp_q.push_back(cur[7:0]);
    exp_q.push_back(cur[15:8]);
    check_rx("midrst_partial");
    push_stack(cur);
    @(negedge clk) g = cur;
    repeat (FRAME + 50) @(posedge clk);
    check_rx("midrst_resend");

    // randomized: glitches, repeats, zeros, new stacks, timestamp changes
    last_m = cur;
    for (int s = 0; s < 15; s++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk) g = {16'($urandom), 32'($urandom)};
      end
      case ($urandom_range(0, 3))
        0: v = cur;
        1: v = '0;
        2: v = {16'($urandom), 32'($urandom)};
        default: v = cur ^ {16'h0, 24'($urandom_range(1, 24'hFFFFFF)), 8'h0};
      endcase
      if (v != 48'h0 && v != last_m) begin
        push_stack(v);
        last_m = v;
      end
      cur = v;
      @(negedge clk) g = v;
      repeat ($urandom_range(850, 1000)) @(posedge clk);
    end
    repeat (100) @(posedge clk);
    check_rx("random");
    chk("random_drop", {63'd0, drop}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
